// File: rtl/present_sbox_pkg.sv
// rtl/present_sbox_pkg.sv - constants and share-domain helpers for the 3-share masked PRESENT S-box layer
package present_sbox_pkg;

   localparam int RW = 24;
   localparam int RQ = 12;

   // Entry i of the unmasked S-box sits at bits [4i+3:4i]: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
   localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

   localparam logic [3:0] IN_AFF_CONST  = 4'h0;
   localparam logic [3:0] MID_AFF_CONST = 4'h7;
   localparam logic [3:0] OUT_AFF_CONST = 4'h0;

   typedef enum logic {Q_STAGE_G, Q_STAGE_F} q_stage_e;

   typedef logic [2:0][3:0] shares_t;

   // prod[k][i][j]: product k, cross term of share i of u with share j of v (remasked when i != j).
   typedef struct packed {
      logic [2:0][2:0][2:0] prod;
      shares_t              lin;
   } q12_reg_t;

   function automatic logic [3:0] sbox_ref(input logic [3:0] n);
      return SBOX_TABLE[4*n +: 4];
   endfunction

   function automatic shares_t aff_const(input shares_t s, input logic [3:0] c);
      shares_t t;
      t    = s;
      t[0] = s[0] ^ c;
      return t;
   endfunction

   // S = F o (G + 0x7): both G and F are quadratic with three AND terms each, nibble bits {x,y,z,w}.
   function automatic logic [3:0] q_lin(input q_stage_e stg, input logic [3:0] a);
      logic x, y, z, w;
      {x, y, z, w} = a;
      if (stg == Q_STAGE_G) return {y ^ z ^ w, y ^ z, x ^ z, w};
      return {y ^ z ^ w, x, y ^ z, z};
   endfunction

   function automatic logic [2:0] q_u(input q_stage_e stg, input logic [3:0] a);
      logic x, y, z, w;
      {x, y, z, w} = a;
      if (stg == Q_STAGE_G) return {y, x, y ^ z};
      return {y, z, x};
   endfunction

   function automatic logic [2:0] q_v(input q_stage_e stg, input logic [3:0] a);
      logic x, y, z, w;
      {x, y, z, w} = a;
      if (stg == Q_STAGE_G) return {z, y ^ z, w};
      return {w, w, w};
   endfunction

   function automatic logic [3:0] q_spread(input q_stage_e stg, input logic [2:0] p);
      if (stg == Q_STAGE_G) return {1'b0, 1'b0, p[0], p[1] ^ p[2]};
      return {p[0], p[1], p[0], p[2]};
   endfunction

   // Domain-oriented expansion: every cross term gets its own mask bit before the register.
   function automatic q12_reg_t q12_expand(input q_stage_e stg, input shares_t s,
                                           input logic [RQ-1:0] r);
      q12_reg_t        q;
      logic [2:0][2:0] u, v;
      int              idx;
      for (int i = 0; i < 3; i++) begin
         u[i]     = q_u(stg, s[i]);
         v[i]     = q_v(stg, s[i]);
         q.lin[i] = q_lin(stg, s[i]);
      end
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               idx = (i + j == 0) ? 0 : (i + j - 1);
               q.prod[k][i][j] = (u[i][k] & v[j][k]) ^ ((i == j) ? 1'b0 : r[3*k + idx]);
            end
         end
      end
      q.lin[0][3] = q.lin[0][3] ^ r[9]  ^ r[10];
      q.lin[1][3] = q.lin[1][3] ^ r[10] ^ r[11];
      q.lin[2][3] = q.lin[2][3] ^ r[11] ^ r[9];
      return q;
   endfunction

   function automatic shares_t q12_compress(input q_stage_e stg, input q12_reg_t q);
      shares_t    o;
      logic [2:0] p;
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 3; k++) p[k] = ^q.prod[k][i];
         o[i] = q.lin[i] ^ q_spread(stg, p);
      end
      return o;
   endfunction

endpackage

// File: rtl/present_sbox_layer_masked_if.sv
// rtl/present_sbox_layer_masked_if.sv - share/randomness stream bundle for the masked S-box layer
interface present_sbox_layer_masked_if #(parameter int NSBOX = 16) ();

   localparam int W = 4 * NSBOX;

   logic [W-1:0]                          in1_i, in2_i, in3_i;
   logic                                  in_valid_i;
   logic                                  in_ready_o;
   logic [present_sbox_pkg::RW*NSBOX-1:0] r_i;
   logic [W-1:0]                          out1_o, out2_o, out3_o;
   logic                                  out_valid_o;
   logic                                  out_ready_i;

   modport slave (
      input  in1_i, in2_i, in3_i, in_valid_i, r_i, out_ready_i,
      output in_ready_o, out1_o, out2_o, out3_o, out_valid_o
   );

   modport master (
      output in1_i, in2_i, in3_i, in_valid_i, r_i, out_ready_i,
      input  in_ready_o, out1_o, out2_o, out3_o, out_valid_o
   );

endinterface

// File: rtl/present_sbox_slice_masked.sv
// rtl/present_sbox_slice_masked.sv - one 3-share PRESENT S-box slice, five register stages gated by adv_i
module present_sbox_slice_masked
   import present_sbox_pkg::*;
(
   input  logic          clk,
   input  logic          rst_i,
   input  logic          adv_i,
   input  logic [3:0]    in1_i,
   input  logic [3:0]    in2_i,
   input  logic [3:0]    in3_i,
   input  logic [RW-1:0] r_i,
   output logic [3:0]    out1_o,
   output logic [3:0]    out2_o,
   output logic [3:0]    out3_o
);

   shares_t  s1_d, s1_q, s3_d, s3_q, s5_d, s5_q, out_sh;
   q12_reg_t s2_d, s2_q, s4_d, s4_q;

   assign s1_d   = aff_const({in3_i, in2_i, in1_i}, IN_AFF_CONST);
   assign s2_d   = q12_expand(Q_STAGE_G, s1_q, r_i[RQ-1:0]);
   assign s3_d   = aff_const(q12_compress(Q_STAGE_G, s2_q), MID_AFF_CONST);
   assign s4_d   = q12_expand(Q_STAGE_F, s3_q, r_i[RW-1:RQ]);
   assign s5_d   = q12_compress(Q_STAGE_F, s4_q);
   assign out_sh = aff_const(s5_q, OUT_AFF_CONST);

   // A stalled cycle must not consume randomness, so every stage shares the one enable.
   always_ff @(posedge clk) begin
      if (!rst_i) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
         s4_q <= '0;
         s5_q <= '0;
      end else if (adv_i) begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
         s4_q <= s4_d;
         s5_q <= s5_d;
      end
   end

   assign out1_o = out_sh[0];
   assign out2_o = out_sh[1];
   assign out3_o = out_sh[2];

endmodule

// File: rtl/present_sbox_layer_masked.sv
// rtl/present_sbox_layer_masked.sv - NSBOX parallel masked S-box slices with valid/ready and global stall
module present_sbox_layer_masked
   import present_sbox_pkg::*;
#(
   parameter int NSBOX = 16
) (
   input  logic                        clk,
   input  logic                        rst_i,
   present_sbox_layer_masked_if.slave  bus
);

   localparam int W = 4 * NSBOX;

   logic [4:0]   v_q, v_d;
   logic         adv;
   logic [W-1:0] out1, out2, out3;

   assign adv            = bus.out_ready_i | ~v_q[4];
   assign bus.in_ready_o = adv;
   assign v_d            = {v_q[3:0], bus.in_valid_i & adv};

   always_ff @(posedge clk) begin
      if (!rst_i) begin
         v_q <= '0;
      end else if (adv) begin
         v_q <= v_d;
      end
   end

   for (genvar k = 0; k < NSBOX; k++) begin : g_slice
      present_sbox_slice_masked u_slice (
         .clk    (clk),
         .rst_i  (rst_i),
         .adv_i  (adv),
         .in1_i  (bus.in1_i[4*k +: 4]),
         .in2_i  (bus.in2_i[4*k +: 4]),
         .in3_i  (bus.in3_i[4*k +: 4]),
         .r_i    (bus.r_i[RW*k +: RW]),
         .out1_o (out1[4*k +: 4]),
         .out2_o (out2[4*k +: 4]),
         .out3_o (out3[4*k +: 4])
      );
   end

   // Shares are gated only by the public valid bit; they are never combined here.
   assign bus.out1_o      = out1 & {W{v_q[4]}};
   assign bus.out2_o      = out2 & {W{v_q[4]}};
   assign bus.out3_o      = out3 & {W{v_q[4]}};
   assign bus.out_valid_o = v_q[4];

endmodule

// File: doc/present_sbox_layer_masked.md
# present_sbox_layer_masked

Second-order (3-share) threshold-masked PRESENT S-box layer: NSBOX independent 5-stage masked S-box slices in parallel, with a valid/ready stream handshake and global pipeline stall. It generalises the fixed single-nibble, free-running 5-stage S-box to a configurable-width datapath for the masked PRESENT round core, placed between key addition and the permutation layer.

## Interface
- NSBOX, default 16: number of parallel 4-bit S-box slices; legal range 1..16.
- RW, fixed 24: fresh random bits per slice per cycle (12 per quadratic stage).
- clk  in  1  rising-edge clock.
- rst_i  in  1  synchronous, active-low reset.
- in1_i / in2_i / in3_i  in  4*NSBOX  input shares 0/1/2; nibble k feeds slice k.
- in_valid_i  in  1  input shares valid.
- in_ready_o  out  1  layer accepts input this cycle.
- r_i  in  RW*NSBOX  fresh randomness; bits [24k+11:24k] feed stage-A quadratic of slice k, [24k+23:24k+12] feed stage-B.
- out1_o / out2_o / out3_o  out  4*NSBOX  output shares; XOR of the three = S(XOR of input shares) per nibble.
- out_valid_o  out  1  output shares valid.
- out_ready_i  in  1  downstream accepts output.

## Operation
- Per slice: input affine -> reg S1 -> quadratic Q12 (internal reg S2) -> middle affine -> reg S3 -> quadratic Q12 (internal reg S4) -> reg S5 -> output affine (combinational) -> outputs.
- Affine layers are linear per share; constant terms added to share 0 only.
- Valid shift register v[1..5] runs alongside the data; out_valid_o = v[5].
- Global advance adv = out_ready_i | ~v[5]. in_ready_o = adv.
- adv=1: all data and valid registers shift; v[1] <= in_valid_i & in_ready_o.
- adv=0: every register (data, valid, Q12-internal) holds; randomness ignored that cycle.
- Bubbles (v=0) propagate; data registers still load when adv=1 regardless of valid.
- r_i must be fresh and uniform in every cycle with adv=1; reuse of r_i across advancing cycles is a usage violation, not detected.
- Share outputs forced to 0 whenever out_valid_o=0 (AND with public valid only; no share-combining logic).
- Shares never XORed together anywhere in the block.

## Timing
- Latency: input accepted at edge t appears with out_valid_o=1 after edge t+4 (5 register stages, output visible in cycle t+5 relative to acceptance cycle 0... i.e. 5 cycles).
- Throughput: one NSBOX-nibble vector per cycle with out_ready_i held 1.
- Reset (rst_i=0 at edge): v[1..5] <= 0, all data registers <= 0. After reset: out_valid_o=0, in_ready_o=1, out1_o/out2_o/out3_o=0.
- Reset mid-stream: all in-flight vectors discarded; no output valid until new input accepted.
- Output held stable (shares and valid) while out_valid_o=1 and out_ready_i=0.
- Simultaneous out_ready_i=0 and in_valid_i=1 with v[5]=1: input not accepted (in_ready_o=0); upstream must hold.
- Pipeline full (v[1..5]=1) with out_ready_i=1: accept and emit in same cycle.

## Structure
- Package present_sbox_pkg: RW constant, 4-bit S-box reference table (C56B90ADE3F8471 2 order: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2), affine-layer constant selectors (input/middle/output).
- Sub-module present_sbox_slice_masked: one 3-share slice, ports clk, rst_i, adv, shares in/out, 24-bit r; holds S1..S5 including enable-gated Q12 stages. Top instantiates NSBOX slices plus valid/handshake logic.

## Test plan
- NSBOX=1, shares (0,0,0), in_valid 1 cycle, out_ready=1 -> out_valid high exactly 5 cycles later, XOR of shares = 0xC.
- NSBOX=16, stream inputs 0x0123456789ABCDEF with random sharing, 20 consecutive vectors, random r_i -> every output XOR = nibble-wise S(x), e.g. 0xC56B90ADE3F84712; one output per cycle, order preserved.
- Same unmasked input with 100 random sharings and random r_i -> identical unmasked output every time; individual shares vary.
- Backpressure: full pipeline, out_ready_i=0 for 3 cycles -> in_ready_o=0, outputs stable; release -> remaining vectors drain in order, none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid pattern identical, delayed 5 cycles; shares 0 during bubbles.
- rst_i=0 for one cycle with 3 vectors in flight -> out_valid_o never asserts for them; in_ready_o=1 next cycle; new input returns correct S-box after 5 cycles.
